btb_assoc: RTL and testbench

- Set-associative branch target buffer with per-entry 2-bit taken-confidence counters. Replaces the direct-mapped BTB.
- Sits in the fetch stage. Looks up all PREFETCH_INSTS fetch PCs in parallel, combinationally.
- Trained by a single retire/resolve write port. Supports a global flush for context switches and mispredict recovery policy.

---
 rtl/btb_assoc_pkg.sv | 29 ++
 rtl/btb_assoc_if.sv | 25 ++
 rtl/btb_assoc_plru_tree.sv | 51 +++++
 rtl/btb_assoc.sv | 147 ++++++++++++++
 tb/tb_btb_assoc.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_assoc_pkg.sv
// rtl/btb_assoc_pkg.sv - shared widths, defaults and entry type for the associative BTB
package btb_assoc_pkg;

   localparam int ADDR_BITS         = 32;
   localparam int PREFETCH_DISTANCE = 2;

   localparam int BTB_SETS     = 16;
   localparam int BTB_WAYS     = 4;
   localparam int BTB_TAG_BITS = 10;
   localparam int BTB_RD_PORTS = PREFETCH_DISTANCE * 2;

   typedef logic [ADDR_BITS-1:0] addr_t;

   typedef struct packed {
      logic                    valid;
      logic [BTB_TAG_BITS-1:0] tag;
      logic [1:0]              ctr;
      addr_t                   target;
   } btb_entry_t;

   // Saturating 2-bit taken-confidence update.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
      else
         return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// rtl/btb_assoc_if.sv - fetch lookup and retire training bundle for the BTB
interface btb_assoc_if #(
   parameter int RD_PORTS = btb_assoc_pkg::BTB_RD_PORTS
);
   btb_assoc_pkg::addr_t rd_pc          [RD_PORTS];
   logic [RD_PORTS-1:0]  rd_hit;
   logic [RD_PORTS-1:0]  rd_pred_taken;
   btb_assoc_pkg::addr_t rd_pred_target [RD_PORTS];

   logic                 wr_en;
   btb_assoc_pkg::addr_t wr_pc;
   logic                 wr_taken;
   btb_assoc_pkg::addr_t wr_target;
   logic                 flush;

   modport master (
      output rd_pc, wr_en, wr_pc, wr_taken, wr_target, flush,
      input  rd_hit, rd_pred_taken, rd_pred_target
   );

   modport slave (
      input  rd_pc, wr_en, wr_pc, wr_taken, wr_target, flush,
      output rd_hit, rd_pred_taken, rd_pred_target
   );
endinterface

// File: rtl/btb_assoc_plru_tree.sv
// rtl/btb_assoc_plru_tree.sv - combinational tree-PLRU touch/victim logic for one set
module plru_tree #(
   parameter  int WAYS     = 4,
   localparam int LOG_WAYS = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]     bits,
   input  logic [LOG_WAYS-1:0] touch_way,
   input  logic                touch_en,
   output logic [WAYS-2:0]     next_bits,
   output logic [LOG_WAYS-1:0] victim_way
);

   // Heap layout: node n has children 2n and 2n+1; a 1 bit points the victim right.
   logic [WAYS-1:1]     tree;
   logic [WAYS-1:1]     next_tree;
   logic [LOG_WAYS-1:0] v_node;
   logic [LOG_WAYS-1:0] t_node;
   logic [LOG_WAYS-1:0] t_way;
   logic                v_dir;
   logic                t_dir;

   assign tree      = bits;
   assign next_bits = next_tree;

   always_comb begin
      v_node     = LOG_WAYS'(1);
      v_dir      = 1'b0;
      victim_way = '0;
      for (int l = 0; l < LOG_WAYS; l++) begin
         v_dir      = tree[v_node];
         victim_way = (victim_way << 1) | LOG_WAYS'(v_dir);
         v_node     = (v_node << 1) | LOG_WAYS'(v_dir);
      end
   end

   always_comb begin
      next_tree = tree;
      t_node    = LOG_WAYS'(1);
      t_way     = touch_way;
      t_dir     = 1'b0;
      if (touch_en) begin
         for (int l = 0; l < LOG_WAYS; l++) begin
            t_dir             = t_way[LOG_WAYS-1];
            next_tree[t_node] = ~t_dir;
            t_way             = t_way << 1;
            t_node            = (t_node << 1) | LOG_WAYS'(t_dir);
         end
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative BTB with 2-bit confidence counters and tree-PLRU replacement
module btb_assoc
   import btb_assoc_pkg::*;
#(
   parameter int SETS     = BTB_SETS,
   parameter int WAYS     = BTB_WAYS,
   parameter int TAG_BITS = BTB_TAG_BITS,
   parameter int RD_PORTS = BTB_RD_PORTS
) (
   input  logic        clock,
   input  logic        reset,
   btb_assoc_if.slave  bus
);

   localparam int LOG_SETS = $clog2(SETS);
   localparam int LOG_WAYS = $clog2(WAYS);
   localparam int TAG_LO   = 2 + LOG_SETS;
   localparam int TAG_HI   = TAG_LO + TAG_BITS;

   typedef logic [LOG_SETS-1:0] idx_t;
   typedef logic [TAG_BITS-1:0] tag_t;
   typedef logic [LOG_WAYS-1:0] way_t;

   logic       valid_q  [SETS][WAYS];
   tag_t       tag_q    [SETS][WAYS];
   logic [1:0] ctr_q    [SETS][WAYS];
   addr_t      target_q [SETS][WAYS];
   logic [WAYS-2:0] plru_q [SETS];

   logic [RD_PORTS-1:0] hit_d;
   logic [RD_PORTS-1:0] taken_d;
   addr_t               target_d [RD_PORTS];
   idx_t                rd_idx;
   tag_t                rd_tag;

   // Descending scan so the lowest-numbered matching way has the final say.
   always_comb begin
      hit_d   = '0;
      taken_d = '0;
      rd_idx  = '0;
      rd_tag  = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         target_d[p] = '0;
         rd_idx      = bus.rd_pc[p][2 +: LOG_SETS];
         rd_tag      = bus.rd_pc[p][TAG_LO +: TAG_BITS];
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
               hit_d[p]    = 1'b1;
               taken_d[p]  = ctr_q[rd_idx][w][1];
               target_d[p] = target_q[rd_idx][w];
            end
         end
      end
   end

   assign bus.rd_hit         = hit_d;
   assign bus.rd_pred_taken  = taken_d;
   assign bus.rd_pred_target = target_d;

   idx_t            wr_idx;
   tag_t            wr_tag;
   logic            wr_hit;
   way_t            wr_hit_way;
   logic            free_found;
   way_t            free_way;
   way_t            victim_way;
   way_t            alloc_way;
   way_t            touch_way;
   logic            touch_en;
   logic [WAYS-2:0] plru_next;

   assign wr_idx = bus.wr_pc[2 +: LOG_SETS];
   assign wr_tag = bus.wr_pc[TAG_LO +: TAG_BITS];

   always_comb begin
      wr_hit     = 1'b0;
      wr_hit_way = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
            wr_hit     = 1'b1;
            wr_hit_way = way_t'(w);
         end
         if (!valid_q[wr_idx][w]) begin
            free_found = 1'b1;
            free_way   = way_t'(w);
         end
      end
   end

   assign alloc_way = free_found ? free_way : victim_way;
   assign touch_way = wr_hit ? wr_hit_way : alloc_way;
   assign touch_en  = wr_hit || bus.wr_taken;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits       (plru_q[wr_idx]),
      .touch_way  (touch_way),
      .touch_en   (touch_en),
      .next_bits  (plru_next),
      .victim_way (victim_way)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w]  <= 1'b0;
               tag_q[s][w]    <= '0;
               ctr_q[s][w]    <= 2'd0;
               target_q[s][w] <= '0;
            end
         end
      end else if (bus.flush) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               ctr_q[s][w]   <= 2'd0;
            end
         end
      end else if (bus.wr_en) begin
         if (wr_hit) begin
            ctr_q[wr_idx][wr_hit_way] <= ctr_step(ctr_q[wr_idx][wr_hit_way], bus.wr_taken);
            if (bus.wr_taken)
               target_q[wr_idx][wr_hit_way] <= bus.wr_target;
            plru_q[wr_idx] <= plru_next;
         end else if (bus.wr_taken) begin
            valid_q[wr_idx][alloc_way]  <= 1'b1;
            tag_q[wr_idx][alloc_way]    <= wr_tag;
            ctr_q[wr_idx][alloc_way]    <= 2'd2;
            target_q[wr_idx][alloc_way] <= bus.wr_target;
            plru_q[wr_idx]              <= plru_next;
         end
      end
   end

   // Offset and aliased high PC bits take no part in indexing or tagging.
   logic unused_pc_bits;
   always_comb begin
      unused_pc_bits = ^{bus.wr_pc[1:0], bus.wr_pc[ADDR_BITS-1:TAG_HI]};
      for (int p = 0; p < RD_PORTS; p++)
         unused_pc_bits = unused_pc_bits ^ (^{bus.rd_pc[p][1:0], bus.rd_pc[p][ADDR_BITS-1:TAG_HI]});
   end

endmodule

// File: tb/tb_btb_assoc.sv
// tb/tb_btb_assoc.sv - directed self-checking bench for btb_assoc with a behavioural BTB model
module tb_btb_assoc;
   import btb_assoc_pkg::*;

   localparam int SETS     = BTB_SETS;
   localparam int WAYS     = BTB_WAYS;
   localparam int TAG_BITS = BTB_TAG_BITS;
   localparam int PORTS    = BTB_RD_PORTS;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   btb_assoc_if #(.RD_PORTS(PORTS)) bus ();

   btb_assoc dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int tests  = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // Behavioural model: per-set entry lists and a tree PLRU kept as a node array.
   bit          m_valid [SETS][WAYS];
   int          m_tag   [SETS][WAYS];
   int          m_ctr   [SETS][WAYS];
   logic [31:0] m_tgt   [SETS][WAYS];
   bit          m_plru  [SETS][WAYS];

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % SETS);
   endfunction

   function automatic int tag_of(logic [31:0] pc);
      return int'((pc >> (2 + $clog2(SETS))) % (1 << TAG_BITS));
   endfunction

   function automatic int m_find(logic [31:0] pc);
      int s = idx_of(pc);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) return w;
      return -1;
   endfunction

   function automatic int m_victim(int s);
      int lo = 0, n = WAYS, node = 1;
      while (n > 1) begin
         n = n / 2;
         if (m_plru[s][node]) begin lo += n; node = 2 * node + 1; end
         else node = 2 * node;
      end
      return lo;
   endfunction

   task automatic m_touch(int s, int w);
      int lo = 0, n = WAYS, node = 1;
      while (n > 1) begin
         n = n / 2;
         m_plru[s][node] = !(w >= lo + n);
         if (w >= lo + n) begin lo += n; node = 2 * node + 1; end
         else node = 2 * node;
      end
   endtask

   task automatic m_clear(bit all);
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = 0; m_ctr[s][w] = 0; m_plru[s][w] = 0;
            if (all) begin m_tag[s][w] = 0; m_tgt[s][w] = 0; end
         end
   endtask

   always @(posedge clock) begin
      if (reset) m_clear(1'b1);
      else if (bus.flush) m_clear(1'b0);
      else if (bus.wr_en) begin
         int s, w;
         s = idx_of(bus.wr_pc);
         w = m_find(bus.wr_pc);
         if (w >= 0) begin
            if (bus.wr_taken) begin
               m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
               m_tgt[s][w] = bus.wr_target;
            end else
               m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
            m_touch(s, w);
         end else if (bus.wr_taken) begin
            w = -1;
            for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[s][k]) w = k;
            if (w < 0) w = m_victim(s);
            m_valid[s][w] = 1; m_tag[s][w] = tag_of(bus.wr_pc);
            m_tgt[s][w] = bus.wr_target; m_ctr[s][w] = 2;
            m_touch(s, w);
         end
      end
   end

   always @(negedge clock) begin
      if (chk_on) begin
         for (int p = 0; p < PORTS; p++) begin
            int w, s;
            logic exp_hit, exp_tk;
            logic [31:0] exp_tg;
            w = m_find(bus.rd_pc[p]);
            s = idx_of(bus.rd_pc[p]);
            exp_hit = (w >= 0);
            exp_tk  = (w >= 0) ? (m_ctr[s][w] >= 2) : 1'b0;
            exp_tg  = (w >= 0) ? m_tgt[s][w] : 32'h0;
            tests += 3;
            if (bus.rd_hit[p] !== exp_hit) begin
               errors++;
               $display("FAIL model_hit[%0d] pc=%h got %b want %b", p, bus.rd_pc[p], bus.rd_hit[p], exp_hit);
            end
            if (bus.rd_pred_taken[p] !== exp_tk) begin
               errors++;
               $display("FAIL model_taken[%0d] pc=%h got %b want %b", p, bus.rd_pc[p], bus.rd_pred_taken[p], exp_tk);
            end
            if (bus.rd_pred_target[p] !== exp_tg) begin
               errors++;
               $display("FAIL model_target[%0d] pc=%h got %h want %h", p, bus.rd_pc[p], bus.rd_pred_target[p], exp_tg);
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      tests++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   task automatic chk_port(string name, int p, logic h, logic t, logic [31:0] tg);
      chk({name, "_hit"}, 32'(bus.rd_hit[p]), 32'(h));
      chk({name, "_taken"}, 32'(bus.rd_pred_taken[p]), 32'(t));
      chk({name, "_target"}, bus.rd_pred_target[p], tg);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_wr(logic en, logic [31:0] pc, logic tk, logic [31:0] tg);
      bus.wr_en = en; bus.wr_pc = pc; bus.wr_taken = tk; bus.wr_target = tg;
   endtask

   task automatic write1(logic [31:0] pc, logic tk, logic [31:0] tg);
      set_wr(1'b1, pc, tk, tg);
      tick();
      set_wr(1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic set_rd(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
      bus.rd_pc[0] = a; bus.rd_pc[1] = b; bus.rd_pc[2] = c; bus.rd_pc[3] = d;
      #1;
   endtask

   task automatic do_reset();
      chk_on = 1'b0;
      reset  = 1'b1;
      tick();
      tick();
      reset  = 1'b0;
      chk_on = 1'b1;
   endtask

   function automatic int m_ctr_of(logic [31:0] pc);
      int w = m_find(pc);
      return (w >= 0) ? m_ctr[idx_of(pc)][w] : -1;
   endfunction

   initial begin
      for (int p = 0; p < PORTS; p++) bus.rd_pc[p] = '0;
      set_wr(1'b0, 32'h0, 1'b0, 32'h0);
      bus.flush = 1'b0;
      do_reset();

      // Reset state, then a write with a concurrent read of the same PC.
      set_rd(32'h1000, 32'h0, 32'h4, 32'h2000);
      chk_port("reset_p0", 0, 1'b0, 1'b0, 32'h0);
      chk_port("reset_p3", 3, 1'b0, 1'b0, 32'h0);
      set_wr(1'b1, 32'h1000, 1'b1, 32'h2000);
      #1;
      chk("same_cycle_hit", 32'(bus.rd_hit[0]), 32'h0);
      tick();
      set_wr(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk_port("alloc", 0, 1'b1, 1'b1, 32'h2000);
      chk("alloc_ctr", 32'(m_ctr_of(32'h1000)), 32'd2);

      // Counter training down and back up.
      write1(32'h1000, 1'b0, 32'h0); #1;
      chk("nt1_ctr", 32'(m_ctr_of(32'h1000)), 32'd1);
      chk_port("nt1", 0, 1'b1, 1'b0, 32'h2000);
      write1(32'h1000, 1'b0, 32'h0); #1;
      chk("nt2_ctr", 32'(m_ctr_of(32'h1000)), 32'd0);
      write1(32'h1000, 1'b0, 32'h0); #1;
      chk("nt3_ctr", 32'(m_ctr_of(32'h1000)), 32'd0);
      chk_port("nt3", 0, 1'b1, 1'b0, 32'h2000);
      write1(32'h1000, 1'b1, 32'h2000); #1;
      chk_port("t1", 0, 1'b1, 1'b0, 32'h2000);
      write1(32'h1000, 1'b1, 32'h2000); #1;
      chk_port("t2", 0, 1'b1, 1'b1, 32'h2000);
      write1(32'h1000, 1'b1, 32'h3000); #1;
      chk_port("retarget", 0, 1'b1, 1'b1, 32'h3000);
      chk("sat_ctr", 32'(m_ctr_of(32'h1000)), 32'd3);

      // Not-taken miss must not allocate.
      write1(32'h0500, 1'b0, 32'h9999);
      set_rd(32'h0500, 32'h1000, 32'h0, 32'h0);
      chk_port("nt_miss", 0, 1'b0, 1'b0, 32'h0);
      chk_port("nt_miss_other", 1, 1'b1, 1'b1, 32'h3000);

      // Fill set 0, touch way 0, overflow: tree PLRU picks way 2 (0x80).
      do_reset();
      write1(32'h0000, 1'b1, 32'h0A00);
      write1(32'h0040, 1'b1, 32'h0A40);
      write1(32'h0080, 1'b1, 32'h0A80);
      write1(32'h00C0, 1'b1, 32'h0AC0);
      write1(32'h0000, 1'b1, 32'h0A00);
      write1(32'h0100, 1'b1, 32'h0B00);
      set_rd(32'h0000, 32'h0040, 32'h0080, 32'h00C0);
      chk_port("ovf_keep0", 0, 1'b1, 1'b1, 32'h0A00);
      chk_port("ovf_keep1", 1, 1'b1, 1'b1, 32'h0A40);
      chk_port("ovf_evict", 2, 1'b0, 1'b0, 32'h0);
      chk_port("ovf_keep3", 3, 1'b1, 1'b1, 32'h0AC0);
      set_rd(32'h0100, 32'h0040, 32'h0080, 32'h00C0);
      chk_port("ovf_new", 0, 1'b1, 1'b1, 32'h0B00);

      // Parallel ports: mixed hits, misses and high-bit aliasing.
      do_reset();
      write1(32'h1000, 1'b1, 32'h2000);
      write1(32'h1004, 1'b1, 32'h2100);
      write1(32'h1008, 1'b1, 32'h2200);
      write1(32'h100C, 1'b1, 32'h2300);
      set_rd(32'h1000, 32'h2004, 32'h1008, 32'h0010);
      chk_port("par0", 0, 1'b1, 1'b1, 32'h2000);
      chk_port("par1", 1, 1'b0, 1'b0, 32'h0);
      chk_port("par2", 2, 1'b1, 1'b1, 32'h2200);
      chk_port("par3", 3, 1'b0, 1'b0, 32'h0);
      set_rd(32'h0001_100C, 32'h1004, 32'h1008, 32'h1000);
      chk_port("alias", 0, 1'b1, 1'b1, 32'h2300);

      // Flush beats a concurrent write.
      bus.flush = 1'b1;
      set_wr(1'b1, 32'h0700, 1'b1, 32'h7700);
      tick();
      bus.flush = 1'b0;
      set_wr(1'b0, 32'h0, 1'b0, 32'h0);
      set_rd(32'h1000, 32'h1004, 32'h1008, 32'h0700);
      chk_port("flush0", 0, 1'b0, 1'b0, 32'h0);
      chk_port("flush_wr", 3, 1'b0, 1'b0, 32'h0);
      write1(32'h1004, 1'b1, 32'h5000);
      #1;
      chk_port("post_flush", 1, 1'b1, 1'b1, 32'h5000);

      tick();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
